// File: rtl/serial_initiator.sv
// Host-side initiator for the 4-word UART debug protocol: sends cmd/addr/data words,
// checks each echo from the target, captures the reply and hands back a response.
module serial_initiator #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        tx_start,
    output logic [31:0] tx_word,
    input  logic        tx_idle,
    input  logic        rx_ready,
    input  logic [31:0] rx_word
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_CMD,
        S_WAIT_CMD_ECHO,
        S_SEND_ADDR,
        S_WAIT_ADDR_ECHO,
        S_SEND_DATA,
        S_WAIT_DATA_ECHO,
        S_WAIT_REPLY,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cmd;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [31:0]        r_rsp_data;
    logic [1:0]         r_rsp_status;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        w_cur_word;
    logic               w_wait;
    logic               w_echo_wait;
    logic               w_expired;
    logic               w_echo_ok;

    // The word in flight: driven on tx_word while sending and reused as the echo reference.
    always_comb begin
        w_cur_word = 32'd0;
        case (r_state)
            S_SEND_CMD,  S_WAIT_CMD_ECHO:  w_cur_word = {28'd0, r_cmd};
            S_SEND_ADDR, S_WAIT_ADDR_ECHO: w_cur_word = r_addr;
            S_SEND_DATA, S_WAIT_DATA_ECHO: w_cur_word = r_data;
            default:                       w_cur_word = 32'd0;
        endcase
    end

    assign w_echo_wait = (r_state == S_WAIT_CMD_ECHO) || (r_state == S_WAIT_ADDR_ECHO) ||
                         (r_state == S_WAIT_DATA_ECHO);
    assign w_wait      = w_echo_wait || (r_state == S_WAIT_REPLY);
    assign w_expired   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_echo_ok   = (rx_word == w_cur_word);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:           if (req_valid) w_next = S_SEND_CMD;
            S_SEND_CMD:       if (tx_idle)   w_next = S_WAIT_CMD_ECHO;
            S_WAIT_CMD_ECHO:  if (rx_ready)  w_next = w_echo_ok ? S_SEND_ADDR : S_RESP;
                              else if (w_expired) w_next = S_RESP;
            S_SEND_ADDR:      if (tx_idle)   w_next = S_WAIT_ADDR_ECHO;
            S_WAIT_ADDR_ECHO: if (rx_ready)  w_next = w_echo_ok ? S_SEND_DATA : S_RESP;
                              else if (w_expired) w_next = S_RESP;
            S_SEND_DATA:      if (tx_idle)   w_next = S_WAIT_DATA_ECHO;
            S_WAIT_DATA_ECHO: if (rx_ready)  w_next = w_echo_ok ? S_WAIT_REPLY : S_RESP;
                              else if (w_expired) w_next = S_RESP;
            S_WAIT_REPLY:     if (rx_ready || w_expired) w_next = S_RESP;
            S_RESP:           if (rsp_ready) w_next = S_IDLE;
            default:          w_next = S_IDLE;
        endcase
    end

    // Outputs decode the state register directly, so reset clears tx_start without waiting for an edge.
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        rsp_valid  = (r_state == S_RESP);
        tx_start   = tx_idle && ((r_state == S_SEND_CMD) || (r_state == S_SEND_ADDR) ||
                                 (r_state == S_SEND_DATA));
        tx_word    = w_cur_word;
        rsp_data   = r_rsp_data;
        rsp_status = r_rsp_status;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd        <= 4'd0;
            r_addr       <= 32'd0;
            r_data       <= 32'd0;
            r_cnt        <= '0;
            r_rsp_data   <= 32'd0;
            r_rsp_status <= ST_OK;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_cmd  <= req_cmd;
                r_addr <= req_addr;
                r_data <= req_data;
            end

            // Restart the wait budget on every state change; count only while waiting.
            if (w_next != r_state)  r_cnt <= '0;
            else if (w_wait)        r_cnt <= r_cnt + CNT_W'(1);

            if (w_echo_wait && rx_ready && !w_echo_ok) begin
                r_rsp_data   <= rx_word;
                r_rsp_status <= ST_MISMATCH;
            end else if (r_state == S_WAIT_REPLY && rx_ready) begin
                r_rsp_data   <= rx_word;
                r_rsp_status <= ST_OK;
            end else if (w_wait && !rx_ready && w_expired) begin
                r_rsp_data   <= 32'd0;
                r_rsp_status <= ST_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_serial_initiator.sv
// Directed bench for serial_initiator: the bench plays the UART target, echoing and replying by hand.
module tb_serial_initiator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_idle = 1'b1;
    logic        rx_ready = 1'b0;
    logic [31:0] rx_word = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    serial_initiator #(.TIMEOUT_CYCLES(50)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .tx_start   (tx_start),
        .tx_word    (tx_word),
        .tx_idle    (tx_idle),
        .rx_ready   (rx_ready),
        .rx_word    (rx_word)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to 2 ns after the next rising edge; inputs are driven and outputs sampled there.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rx_ready  = 1'b0;
        tx_idle   = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic issue_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_rx(input logic [31:0] w);
        rx_ready = 1'b1;
        rx_word  = w;
        tick();
        rx_ready = 1'b0;
    endtask

    // Waits a bounded number of cycles for a tx_start pulse and reports the word it carried.
    task automatic wait_tx(output logic ok, output logic [31:0] w);
        ok = 1'b0;
        w  = 32'd0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                w  = tx_word;
                tick();
                return;
            end
            tick();
        end
    endtask

    // Plays a well-behaved target for the three request words; echoes the words the host asked for.
    task automatic send_all(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                            output logic [2:0] oks, output logic [31:0] w0,
                            output logic [31:0] w1, output logic [31:0] w2);
        wait_tx(oks[0], w0);
        pulse_rx({28'd0, c});
        wait_tx(oks[1], w1);
        pulse_rx(a);
        wait_tx(oks[2], w2);
        pulse_rx(d);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, tx_start} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready/valid/start=%b required 100",
                     {req_ready, rsp_valid, tx_start});
        end
        n_cmp++;
        if ({tx_word, rsp_data, rsp_status} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_data: got tx_word=%h rsp_data=%h status=%b required zeros",
                     tx_word, rsp_data, rsp_status);
        end
    endtask

    task automatic test_happy();
        logic ok;
        logic [31:0] w;
        issue_req(4'h2, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx(ok, w);
        n_cmp++;
        if ({ok, w} !== {1'b1, 32'h0000_0002}) begin
            n_err++;
            $display("FAIL happy_cmd_word: got ok=%b word=%h required 1/00000002", ok, w);
        end
        #1;
        n_cmp++;
        if (tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL happy_single_pulse: tx_start=%b one cycle after pulse, required 0", tx_start);
        end
        pulse_rx(32'h0000_0002);
        wait_tx(ok, w);
        n_cmp++;
        if ({ok, w} !== {1'b1, 32'h0000_1000}) begin
            n_err++;
            $display("FAIL happy_addr_word: got ok=%b word=%h required 1/00001000", ok, w);
        end
        pulse_rx(32'h0000_1000);
        wait_tx(ok, w);
        n_cmp++;
        if ({ok, w} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL happy_data_word: got ok=%b word=%h required 1/deadbeef", ok, w);
        end
        pulse_rx(32'hDEAD_BEEF);
        pulse_rx(32'h1234_5678);
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, rsp_status, rsp_data} !== {1'b1, 1'b0, 2'b00, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL happy_rsp: got valid=%b ready=%b status=%b data=%h required 1/0/00/12345678",
                     rsp_valid, req_ready, rsp_status, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL happy_accept: got valid/ready=%b required 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_mismatch();
        logic ok;
        logic [31:0] w;
        logic seen_start;
        issue_req(4'h2, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx(ok, w);
        pulse_rx(32'h0000_0002);
        wait_tx(ok, w);
        pulse_rx(32'h0000_1001);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b01, 32'h0000_1001}) begin
            n_err++;
            $display("FAIL mismatch_rsp: got valid=%b status=%b data=%h required 1/01/00001001",
                     rsp_valid, rsp_status, rsp_data);
        end
        seen_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (tx_start !== 1'b0) seen_start = 1'b1;
        end
        n_cmp++;
        if (seen_start !== 1'b0) begin
            n_err++;
            $display("FAIL mismatch_no_data_tx: got tx_start pulse=%b required 0", seen_start);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_stray_and_coincidence();
        logic [2:0] oks;
        logic [31:0] w0, w1, w2;
        pulse_rx(32'hFFFF_FFFF);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, tx_start} !== 3'b100) begin
            n_err++;
            $display("FAIL stray_idle: got ready/valid/start=%b required 100",
                     {req_ready, rsp_valid, tx_start});
        end
        issue_req(4'hA, 32'h0000_0040, 32'h0000_0055);
        send_all(4'hA, 32'h0000_0040, 32'h0000_0055, oks, w0, w1, w2);
        n_cmp++;
        if ({oks, w0, w1, w2} !== {3'b111, 32'h0000_000A, 32'h0000_0040, 32'h0000_0055}) begin
            n_err++;
            $display("FAIL coinc_words: got ok=%b %h %h %h required 111 0000000a 00000040 00000055",
                     oks, w0, w1, w2);
        end
        // 49 cycles into the reply wait is the last cycle before the timeout fires.
        repeat (49) tick();
        pulse_rx(32'hAABB_CCDD);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b00, 32'hAABB_CCDD}) begin
            n_err++;
            $display("FAIL coinc_rsp: got valid=%b status=%b data=%h required 1/00/aabbccdd",
                     rsp_valid, rsp_status, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [2:0] oks;
        logic [31:0] w0, w1, w2;
        logic early;
        issue_req(4'h7, 32'h0000_0100, 32'h0000_0200);
        send_all(4'h7, 32'h0000_0100, 32'h0000_0200, oks, w0, w1, w2);
        early = 1'b0;
        for (int i = 0; i < 49; i++) begin
            if (rsp_valid !== 1'b0) early = 1'b1;
            tick();
        end
        n_cmp++;
        if ({early, rsp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_early: got early/valid@49=%b required 00", {early, rsp_valid});
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL timeout_rsp: got valid=%b status=%b data=%h required 1/10/00000000",
                     rsp_valid, rsp_status, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [31:0] w;
        logic bad;
        tx_idle = 1'b0;
        issue_req(4'h3, 32'h0000_2000, 32'h0BAD_F00D);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (tx_start !== 1'b0) bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL busy_tx_withheld: got tx_start while busy=%b required 0", bad);
        end
        tx_idle = 1'b1;
        #1;
        n_cmp++;
        if ({tx_start, tx_word} !== {1'b1, 32'h0000_0003}) begin
            n_err++;
            $display("FAIL busy_tx_release: got start=%b word=%h required 1/00000003", tx_start, tx_word);
        end
        wait_tx(ok, w);
        pulse_rx(32'h0000_0003);
        wait_tx(ok, w);
        pulse_rx(32'h0000_2000);
        wait_tx(ok, w);
        pulse_rx(32'h0BAD_F00D);
        pulse_rx(32'hCAFE_F00D);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                rx_ready = 1'b1;
                rx_word  = 32'h5555_AAAA;
            end else begin
                rx_ready = 1'b0;
            end
            #1;
            if ({rsp_valid, req_ready, rsp_status, rsp_data} !== {1'b1, 1'b0, 2'b00, 32'hCAFE_F00D})
                bad = 1'b1;
            tick();
        end
        rx_ready = 1'b0;
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_hold: got unstable rsp or req_ready during backpressure=%b required 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rsp_release: got valid/ready=%b required 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        logic [31:0] w;
        logic [2:0] oks;
        logic [31:0] w0, w1, w2;
        do_reset();
        issue_req(4'h2, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx(ok, w);
        pulse_rx(32'h0000_0002);
        wait_tx(ok, w);
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_start, rsp_valid, req_ready, tx_word} !== {3'b001, 32'h0}) begin
            n_err++;
            $display("FAIL areset_wait_echo: got start/valid/ready=%b word=%h required 001/00000000",
                     {tx_start, rsp_valid, req_ready}, tx_word);
        end
        tick();
        reset_n = 1'b1;
        tick();
        issue_req(4'h9, 32'h0000_3000, 32'h0000_4000);
        #1;
        n_cmp++;
        if (tx_start !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: got tx_start=%b in send state required 1", tx_start);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_start, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL areset_mid_pulse: got start/ready=%b required 01", {tx_start, req_ready});
        end
        tick();
        reset_n = 1'b1;
        tick();
        issue_req(4'h4, 32'h0000_0ABC, 32'h1357_9BDF);
        send_all(4'h4, 32'h0000_0ABC, 32'h1357_9BDF, oks, w0, w1, w2);
        pulse_rx(32'h0F0F_0F0F);
        #1;
        n_cmp++;
        if ({oks, w0, w1, w2, rsp_valid, rsp_status, rsp_data} !==
            {3'b111, 32'h4, 32'h0000_0ABC, 32'h1357_9BDF, 1'b1, 2'b00, 32'h0F0F_0F0F}) begin
            n_err++;
            $display("FAIL areset_after_txn: got ok=%b %h %h %h valid=%b status=%b data=%h required 111 00000004 00000abc 13579bdf 1 00 0f0f0f0f",
                     oks, w0, w1, w2, rsp_valid, rsp_status, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_happy();
        test_mismatch();
        test_stray_and_coincidence();
        test_timeout();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_initiator.md
Name: serial_initiator

Overview:
Host-side initiator for the 4-word UART debug protocol (cmd, addr, data, reply). It accepts one debug request over a valid/ready handshake and sends cmd, addr and data as 32-bit words. It checks each word's echo from the target and captures the 32-bit reply. It sits between a local request source (bench master, hardware-in-the-loop sequencer) and externally instantiated uart_tx_word / uart_rx_word blocks.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed per wait state (each echo, reply) before abort; must be >= 2
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  initiator can accept request (high only in S_IDLE)
req_cmd  input  4  command nibble
req_addr  input  32  target address
req_data  input  32  write data
rsp_valid  output  1  response available, held until accepted
rsp_ready  input  1  response consumer ready
rsp_data  output  32  reply word from target
rsp_status  output  2  00 ok, 01 echo mismatch, 10 timeout, 11 unused
tx_start  output  1  one-cycle start pulse to uart_tx_word
tx_word  output  32  word to transmit
tx_idle  input  1  uart_tx_word idle
rx_ready  input  1  one-cycle pulse, rx_word valid (uart_rx_word)
rx_word  input  32  received word

Behaviour:
- Reset (async, reset_n low): state S_IDLE; req_ready 1; rsp_valid 0; rsp_data 0; rsp_status 00; tx_start 0; tx_word 0; counter 0; latched request 0. tx_start must drop in the same instant as reset is asserted, including mid-transfer.
- States: S_IDLE, S_SEND_CMD, S_WAIT_CMD_ECHO, S_SEND_ADDR, S_WAIT_ADDR_ECHO, S_SEND_DATA, S_WAIT_DATA_ECHO, S_WAIT_REPLY, S_RESP.
- S_IDLE: on req_valid && req_ready, latch cmd/addr/data and go to S_SEND_CMD. rx_ready pulses in S_IDLE and S_RESP are discarded.
- S_SEND_x: when tx_idle = 1, drive tx_start = 1 for exactly one cycle and tx_word = the word, then go to S_WAIT_x_ECHO and clear the counter. While tx_idle = 0, stay; this state has no timeout.
  - cmd word is {28'b0, cmd}; addr and data words are sent verbatim.
- S_WAIT_x_ECHO: counter increments each cycle. tx_idle is not checked here, so an echo arriving on any cycle after tx_start is accepted. On rx_ready:
  - rx_word equals the sent word: go to the next S_SEND state (after data echo, S_WAIT_REPLY).
  - rx_word differs: rsp_status 01, rsp_data = offending rx_word, go to S_RESP.
- Timeout rule: if no rx_ready by the time the counter reaches TIMEOUT_CYCLES-1, then rsp_status 10, rsp_data 0, go to S_RESP. When rx_ready and expiry coincide, rx_ready wins.
- S_WAIT_REPLY: same counter and timeout rule. On rx_ready: rsp_data = rx_word, rsp_status 00, go to S_RESP. Any 32-bit value is a valid reply; no check.
- S_RESP: rsp_valid 1. rsp_data and rsp_status stay stable until rsp_valid && rsp_ready, then go to S_IDLE. req_ready returns high the cycle after acceptance.
- Min latency from request acceptance to rsp_valid: 1 + 3*(send + echo) + reply cycles; dominated by UART timing.
- After an abort there is no retry and no resynchronisation. The next request starts fresh; target recovery belongs to the host.
- Exactly one tx_start pulse per transmitted word; never two pulses without an intervening tx_idle = 1.

Test Plan:
- Write/read happy path: req cmd=4'h2, addr=32'h0000_1000, data=32'hDEAD_BEEF. Model echoes 0x2, 0x1000, 0xDEADBEEF, then replies 32'h1234_5678. Expect three tx_start pulses with matching tx_word, then rsp_valid with rsp_data=32'h12345678, status 00.
- Echo mismatch: model echoes addr as 32'h0000_1001. Expect no third tx_start; rsp_status 01, rsp_data 32'h00001001.
- Timeout: TIMEOUT_CYCLES=50 and the model never replies after data echo. Expect rsp_valid exactly 50 cycles after entering S_WAIT_REPLY, status 10, rsp_data 0.
- Backpressure and busy TX: hold tx_idle=0 for 20 cycles in S_SEND_CMD. Expect tx_start withheld until tx_idle rises. Hold rsp_ready=0 for 10 cycles; expect rsp_* stable and req_ready=0 throughout.
- Stray rx and coincidence: rx_ready pulse in S_IDLE is ignored (no state change). An rx_ready arriving on the timeout-expiry cycle yields status 00.
- Async reset mid-transfer: assert reset_n=0 during S_WAIT_ADDR_ECHO. Expect immediate tx_start=0, rsp_valid=0, req_ready=1. A following full transaction completes with status 00.
